// File: rtl/pll_pkg.sv
// Shared PLL-model definitions: FSM state encoding and period word width.
package pll_pkg;

  localparam int PERIOD_W = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRACK     = 2'd1,
    LOCKED_ST = 2'd2
  } lock_state_t;

  // Widened so the subtraction can neither wrap nor overflow.
  function automatic logic [PERIOD_W:0] abs_diff(
    input logic [PERIOD_W-1:0] a,
    input logic [PERIOD_W-1:0] b
  );
    logic [PERIOD_W:0] wa;
    logic [PERIOD_W:0] wb;
    wa = {1'b0, a};
    wb = {1'b0, b};
    return (wa >= wb) ? (wa - wb) : (wb - wa);
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample timer; tick marks the last cycle of each interval.
module sample_tick_gen
  import pll_pkg::*;
#(
  parameter int SAMPLE_CYCLES = 16
) (
  input  logic clk,
  input  logic RST,
  input  logic PWRDWN,
  output logic o_tick
);

  localparam int TW = $clog2(SAMPLE_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(SAMPLE_CYCLES - 1);

  logic [TW-1:0] r_timer;

  always_ff @(posedge clk) begin
    if (!RST || PWRDWN) begin
      r_timer <= '0;
    end else if (r_timer == LAST) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign o_tick = (r_timer == LAST);

endmodule

// File: rtl/period_lock_detect.sv
// Lock detector: qualifies the measured period once it has been stable
// for LOCK_COUNT consecutive samples within TOLERANCE_1000.
module period_lock_detect
  import pll_pkg::*;
#(
  parameter int SAMPLE_CYCLES  = 16,
  parameter int LOCK_COUNT     = 4,
  parameter int TOLERANCE_1000 = 100,
  localparam int MCW = $clog2(LOCK_COUNT + 1)
) (
  input  logic                clk,
  input  logic                RST,
  input  logic                PWRDWN,
  input  logic [PERIOD_W-1:0] period_length_1000,
  output logic                LOCKED,
  output logic [PERIOD_W-1:0] period_locked_1000,
  output logic [MCW-1:0]      match_count,
  output logic                unlock_event
);

  localparam logic [MCW-1:0]    LC  = MCW'(LOCK_COUNT);
  localparam logic [PERIOD_W:0] TOL = (PERIOD_W + 1)'(TOLERANCE_1000);

  lock_state_t         r_state;
  logic [PERIOD_W-1:0] r_anchor;
  logic [PERIOD_W-1:0] r_plock;
  logic [MCW-1:0]      r_mc;
  logic                r_locked;
  logic                r_unlock;

  logic                w_tick;
  logic                w_nz;
  logic                w_match;
  logic [PERIOD_W:0]   w_diff;
  logic [MCW-1:0]      w_mc_inc;

  sample_tick_gen #(
    .SAMPLE_CYCLES(SAMPLE_CYCLES)
  ) u_tick (
    .clk   (clk),
    .RST   (RST),
    .PWRDWN(PWRDWN),
    .o_tick(w_tick)
  );

  assign w_nz     = (period_length_1000 != '0);
  assign w_diff   = abs_diff(period_length_1000, r_anchor);
  assign w_match  = (w_diff <= TOL);
  assign w_mc_inc = r_mc + 1'b1;

  always_ff @(posedge clk) begin
    if (!RST || PWRDWN) begin
      r_state  <= IDLE;
      r_anchor <= '0;
      r_plock  <= '0;
      r_mc     <= '0;
      r_locked <= 1'b0;
      r_unlock <= 1'b0;
    end else begin
      r_unlock <= 1'b0;
      if (w_tick) begin
        unique case (r_state)
          IDLE: begin
            if (w_nz) begin
              r_anchor <= period_length_1000;
              r_mc     <= '0;
              r_state  <= TRACK;
            end
          end
          TRACK: begin
            if (!w_nz) begin
              r_mc    <= '0;
              r_state <= IDLE;
            end else if (w_match) begin
              r_mc <= w_mc_inc;
              if (w_mc_inc == LC) begin
                r_locked <= 1'b1;
                r_plock  <= period_length_1000;
                r_state  <= LOCKED_ST;
              end
            end else begin
              // Anchor only moves on a mismatch so slow drift cannot lock.
              r_anchor <= period_length_1000;
              r_mc     <= '0;
            end
          end
          LOCKED_ST: begin
            if (w_nz && w_match) begin
              r_plock <= period_length_1000;
            end else begin
              r_locked <= 1'b0;
              r_plock  <= '0;
              r_unlock <= 1'b1;
              r_mc     <= '0;
              if (w_nz) begin
                r_anchor <= period_length_1000;
                r_state  <= TRACK;
              end else begin
                r_state  <= IDLE;
              end
            end
          end
          default: begin
            r_mc    <= '0;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign LOCKED             = r_locked;
  assign period_locked_1000 = r_plock;
  assign match_count        = r_mc;
  assign unlock_event       = r_unlock;

endmodule

// File: tb/tb_period_lock_detect.sv
// Directed table-driven bench for period_lock_detect at default parameters.
module tb_period_lock_detect;

  logic        clk = 1'b0;
  logic        RST;
  logic        PWRDWN;
  logic [31:0] period_length_1000;
  logic        LOCKED;
  logic [31:0] period_locked_1000;
  logic [2:0]  match_count;
  logic        unlock_event;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  period_lock_detect dut (
    .clk               (clk),
    .RST               (RST),
    .PWRDWN            (PWRDWN),
    .period_length_1000(period_length_1000),
    .LOCKED            (LOCKED),
    .period_locked_1000(period_locked_1000),
    .match_count       (match_count),
    .unlock_event      (unlock_event)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        pd;
    logic [31:0] per;
    int          cyc;
    logic        e_lk;
    logic [31:0] e_pl;
    logic [2:0]  e_mc;
    logic        e_ue;
  } vec_t;

  vec_t v[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic lk,
                         input logic [31:0] pl, input logic [2:0] mc,
                         input logic ue);
    chk({nm, ".LOCKED"}, 32'(LOCKED), 32'(lk));
    chk({nm, ".plock"}, period_locked_1000, pl);
    chk({nm, ".mc"}, 32'(match_count), 32'(mc));
    chk({nm, ".unlock"}, 32'(unlock_event), 32'(ue));
  endtask

  task automatic add(input string nm, input logic r, input logic p,
                     input logic [31:0] per, input int c, input logic lk,
                     input logic [31:0] pl, input logic [2:0] mc,
                     input logic ue);
    vec_t t;
    t.name = nm; t.rst = r; t.pd = p; t.per = per; t.cyc = c;
    t.e_lk = lk; t.e_pl = pl; t.e_mc = mc; t.e_ue = ue;
    v.push_back(t);
  endtask

  initial begin
    // Edge numbers in names count from reset release.
    add("e79",   1, 0, 10000, 79, 0, 0,     3, 0);
    add("e80",   1, 0, 10000,  1, 1, 10000, 4, 0);
    add("e240",  1, 0, 10000,160, 1, 10000, 4, 0);
    add("jit+",  1, 0, 10050, 16, 1, 10050, 4, 0);
    add("jit-",  1, 0,  9950, 16, 1,  9950, 4, 0);
    add("stp287",1, 0, 13000, 15, 1,  9950, 4, 0);
    add("stp288",1, 0, 13000,  1, 0,     0, 0, 1);
    add("stp289",1, 0, 13000,  1, 0,     0, 0, 0);
    add("rel351",1, 0, 13000, 62, 0,     0, 3, 0);
    add("rel352",1, 0, 13000,  1, 1, 13000, 4, 0);
    add("los367",1, 0,     0, 15, 1, 13000, 4, 0);
    add("los368",1, 0,     0,  1, 0,     0, 0, 1);
    add("los400",1, 0,     0, 32, 0,     0, 0, 0);
    add("rst479",1, 0, 10000, 79, 0,     0, 3, 0);
    add("rst480",1, 0, 10000,  1, 1, 10000, 4, 0);
    add("pd496", 1, 0, 20000, 16, 0,     0, 0, 1);
    add("pd528", 1, 0, 20000, 32, 0,     0, 2, 0);
    add("pd530", 1, 0, 20000,  2, 0,     0, 2, 0);
    add("pdon",  1, 1, 20000,  2, 0,     0, 0, 0);
    add("pd79",  1, 0, 20000, 79, 0,     0, 3, 0);
    add("pd80",  1, 0, 20000,  1, 1, 20000, 4, 0);
    add("rstlk", 0, 1, 20000,  1, 0,     0, 0, 0);
    add("tolA",  1, 0, 10000, 16, 0,     0, 0, 0);
    add("tol100",1, 0, 10100, 16, 0,     0, 1, 0);
    add("tol101",1, 0, 10101, 16, 0,     0, 0, 0);
    add("anc+",  1, 0, 10201, 16, 0,     0, 1, 0);
    add("anc-",  1, 0, 10001, 16, 0,     0, 2, 0);
    add("anc101",1, 0, 10000, 16, 0,     0, 0, 0);

    RST = 1'b0;
    PWRDWN = 1'b0;
    period_length_1000 = 32'd10000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_all($sformatf("rsthold%0d", i), 0, 0, 0, 0);
    end

    foreach (v[i]) begin
      RST = v[i].rst;
      PWRDWN = v[i].pd;
      period_length_1000 = v[i].per;
      repeat (v[i].cyc) @(posedge clk);
      #1;
      chk_all(v[i].name, v[i].e_lk, v[i].e_pl, v[i].e_mc, v[i].e_ue);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
